iter32_divider: RTL and testbench

Iterative 32-bit integer divider, the division counterpart of the team's 32-cycle iterative multiplier, sitting beside it in the processor's execute stage. It accepts a dividend/divisor pair with a signed/unsigned flag and computes one quotient bit per cycle by restoring division. It holds the processor with `stall` and then presents quotient and remainder for one cycle under `out_valid`. Divide-by-zero and signed overflow follow RISC-V M-extension semantics.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 27 ++
 rtl/iter32_divider.sv | 128 ++++++++++++
 tb/tb_iter32_divider.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding,
// iteration count, divide-by-zero quotient and a two's-complement helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        END  = 2'd2
    } div_state_t;

    localparam int          DIV_ITERS  = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor magnitude when the partial remainder covers it.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dsr_ext;

    always_comb begin
        shifted = {rem_in[WIDTH-1:0], bit_in};
        dsr_ext = {1'b0, dsr};
        rem_out = shifted;
        q_bit   = 1'b0;
        if (shifted >= dsr_ext) begin
            rem_out = shifted - dsr_ext;
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/iter32_divider.sv
// 32-cycle iterative signed/unsigned divider for the execute stage; holds the
// pipeline with stall and presents quotient/remainder for one cycle.
module iter32_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             out_valid,
    output logic             stall,
    output div_state_t       state_dbg
);

    localparam int CW = $clog2(DIV_ITERS);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH:0]   rem_r;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] final_q;
    logic [WIDTH-1:0] final_r;

    // Handshake: a request is taken on any cycle where state is IDLE and
    // in_valid is high; stall stays high from that cycle until the result
    // cycle, and out_valid marks the single cycle the result is presented.
    always_comb begin
        stall = ((state == IDLE) && in_valid) || (state == OP);
    end

    assign state_dbg = state;

    always_comb begin
        a_mag = (is_signed && dividend[WIDTH-1]) ? neg32(dividend) : dividend;
        b_mag = (is_signed && divisor[WIDTH-1])  ? neg32(divisor)  : divisor;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .bit_in  (dvd_r[WIDTH-1]),
        .dsr     (dsr_r),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Final-iteration result with sign correction, loaded as END is entered
    // so the registered outputs are visible during the END cycle.
    always_comb begin
        final_q = {quo_r[WIDTH-2:0], step_q};
        final_r = step_rem[WIDTH-1:0];
        if (neg_q) final_q = neg32(final_q);
        if (neg_r) final_r = neg32(final_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd_r     <= '0;
            dsr_r     <= '0;
            quo_r     <= '0;
            rem_r     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= is_signed & dividend[WIDTH-1];
                        dvd_r <= a_mag;
                        dsr_r <= b_mag;
                        rem_r <= '0;
                        quo_r <= '0;
                        cnt   <= '0;
                        if (divisor == '0) begin
                            quotient  <= DIV_ZERO_Q;
                            remainder <= dividend;
                            out_valid <= 1'b1;
                            state     <= END;
                        end else begin
                            state <= OP;
                        end
                    end
                end
                OP: begin
                    rem_r <= step_rem;
                    dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
                    quo_r <= {quo_r[WIDTH-2:0], step_q};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(DIV_ITERS - 1)) begin
                        cnt       <= '0;
                        quotient  <= final_q;
                        remainder <= final_r;
                        out_valid <= 1'b1;
                        state     <= END;
                    end
                end
                END: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter32_divider.sv
// Directed and randomized checks of iter32_divider with a result scoreboard.
module tb_iter32_divider;
    import div_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        out_valid;
    logic        stall;
    div_state_t  state_dbg;

    int checks;
    int errors;
    logic [31:0] exp_q[$];
    logic [31:0] exp_r_q[$];

    iter32_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .out_valid (out_valid),
        .stall     (stall),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request at the current negedge (cycle 0) and record the expected result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        exp_q.push_back(eq);
        exp_r_q.push_back(er);
        #1;
        chk("stall_accept", 32'(stall), 32'd1);
    endtask

    // Step cycles until out_valid (bounded), then score the result against the queue.
    task automatic finish_req(input int lat);
        int cyc;
        logic stall_dropped;
        logic [31:0] eq;
        logic [31:0] er;
        stall_dropped = 1'b0;
        @(negedge clk);
        cyc = 1;
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (stall !== 1'b1) stall_dropped = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("stall_busy", 32'(stall_dropped), 32'd0);
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("latency", cyc, lat);
        chk("stall_end", 32'(stall), 32'd0);
        eq = exp_q.pop_front();
        er = exp_r_q.pop_front();
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        @(negedge clk);
        chk("pulse_one", 32'(out_valid), 32'd0);
        chk("back_idle", 32'(state_dbg), 32'(IDLE));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int sa;
        int sb;
        logic ov_seen;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;

        repeat (3) @(negedge clk);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // unsigned and signed basics
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        finish_req(33);
        issue(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF);
        finish_req(33);

        // divide by zero, both modes, remainder left unmodified
        issue(32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5);
        finish_req(1);
        issue(32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd5);
        finish_req(1);
        issue(32'hFFFFFFF8, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF8);
        finish_req(1);

        // signed overflow and the same operands unsigned
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0);
        finish_req(33);
        issue(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000);
        finish_req(33);

        // boundaries: divisor larger than dividend, divide by one, full-range unsigned
        issue(32'd3, 32'd10, 1'b0, 32'd0, 32'd3);
        finish_req(33);
        issue(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0);
        finish_req(33);
        issue(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1);
        finish_req(33);

        // random unsigned
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom_range(1, 100000);
            issue(a, b, 1'b0, a / b, a % b);
            finish_req(33);
        end

        // random signed, divisor magnitude kept >= 2 to stay clear of overflow
        for (int i = 0; i < 4; i++) begin
            sa = int'($urandom);
            sb = int'($urandom_range(2, 5000));
            if ($urandom_range(0, 1) == 1) sb = -sb;
            issue(32'(sa), 32'(sb), 1'b1, 32'(sa / sb), 32'(sa % sb));
            finish_req(33);
        end

        // new request held during OP and END must be ignored until IDLE
        issue(32'd200, 32'd9, 1'b0, 32'd22, 32'd2);
        for (int cyc = 1; cyc <= 32; cyc++) begin
            @(negedge clk);
            if (cyc == 1) in_valid = 1'b0;
            if (cyc == 5) begin
                in_valid = 1'b1;
                dividend = 32'd77;
                divisor  = 32'd5;
            end
        end
        chk("ign_stall_c32", 32'(stall), 32'd1);
        @(negedge clk);
        chk("ign_out_valid", 32'(out_valid), 32'd1);
        chk("ign_stall_end", 32'(stall), 32'd0);
        chk("ign_quotient", quotient, exp_q.pop_front());
        chk("ign_remainder", remainder, exp_r_q.pop_front());
        @(negedge clk);
        chk("ign_pulse", 32'(out_valid), 32'd0);
        issue(32'd77, 32'd5, 1'b0, 32'd15, 32'd2);
        finish_req(33);

        // reset in the middle of an operation
        issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);
        void'(exp_q.pop_back());
        void'(exp_r_q.pop_back());
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) in_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_quotient", quotient, 32'd0);
        chk("mid_rst_remainder", remainder, 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ov_seen = 1'b1;
        end
        chk("aborted_no_valid", 32'(ov_seen), 32'd0);
        issue(32'd9, 32'd4, 1'b0, 32'd2, 32'd1);
        finish_req(33);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
